// File: rtl/cprs_pkg.sv
// Shared types and helpers for the popcount accumulator: FSM states, count
// width, and the approximate 4-bit group count used when CPRS_APPROX_EN is set.
package cprs_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, OUT} state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Group {a,b,c,d} = g[0..3]: 2*((a&b)|(c&d)) + ((a^b)|(c^d))
  function automatic logic [1:0] approx_grp(input logic [3:0] g);
    return {(g[0] & g[1]) | (g[2] & g[3]), (g[0] ^ g[1]) | (g[2] ^ g[3])};
  endfunction

endpackage

// File: rtl/cprs_popcnt_acc_if.sv
// Beat input stream and frame-result output stream of the popcount accumulator.
interface cprs_popcnt_acc_if #(
  parameter int N_IN  = 7,
  parameter int ACC_W = 16
);
  logic [N_IN-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] out_cnt;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_cnt, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_cnt, out_sat, out_valid
  );
endinterface

// File: rtl/cprs_tree_n.sv
// Combinational N_IN -> CW bit counter: chain of 3:2 compressors down to two
// rows, then one ripple add. CPRS_APPROX_EN switches 4-bit groups to approx mode.
module cprs_tree_n
  import cprs_pkg::*;
#(
  parameter  int N_IN = 7,
  localparam int CW   = cnt_width(N_IN)
) (
  input  logic [N_IN-1:0] bits,
  output logic [CW-1:0]   cnt
);

`ifdef CPRS_APPROX_EN
  localparam int NG = N_IN / 4;
`else
  localparam int NG = 0;
`endif
  localparam int NR = N_IN - 4 * NG;
  localparam int NT = NG + NR;

  logic [CW-1:0] term [NT];

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      assign term[gi] = CW'(approx_grp(bits[4*gi +: 4]));
    end
    for (gi = 0; gi < NR; gi++) begin : g_bit
      assign term[NG+gi] = CW'(bits[4*NG+gi]);
    end

    // Carry out of the top column can be dropped: the true total always fits CW bits.
    for (gi = 0; gi < NT; gi++) begin : g_csa
      logic [CW-1:0] s_in, c_in, s_o, c_o, maj;
      if (gi == 0) begin : g_first
        assign s_in = '0;
        assign c_in = '0;
      end else begin : g_next
        assign s_in = g_csa[gi-1].s_o;
        assign c_in = g_csa[gi-1].c_o;
      end
      assign maj = (s_in & c_in) | (s_in & term[gi]) | (c_in & term[gi]);
      assign s_o = s_in ^ c_in ^ term[gi];
      assign c_o = {maj[CW-2:0], 1'b0};
    end
  endgenerate

  assign cnt = g_csa[NT-1].s_o + g_csa[NT-1].c_o;

endmodule

// File: rtl/cprs_popcnt_acc.sv
// Frame popcount accumulator: per-beat compressor tree, stage register, saturating
// frame sum, valid/ready result. Optional CPRS_APPROX_EN selects approximate counting.
module cprs_popcnt_acc
  import cprs_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int ACC_W = 16
) (
  input logic               clk,
  input logic               rst,
  cprs_popcnt_acc_if.slave  bus
);

  localparam int CW = cnt_width(N_IN);
  localparam int SW = ACC_W + 1;

  state_t           state_reg, state_next;
  logic [CW-1:0]    pc;
  logic [CW-1:0]    pc_reg;
  logic             pc_valid_reg, pc_last_reg;
  logic [ACC_W-1:0] acc_reg, out_cnt_reg;
  logic             sat_reg, out_sat_reg;
  logic [SW-1:0]    sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic             sum_ovf;
  logic             accept, consume;

  cprs_tree_n #(.N_IN(N_IN)) u_tree (
    .bits (bus.in_data),
    .cnt  (pc)
  );

  assign accept  = bus.in_valid  & (state_reg == RUN);
  assign consume = bus.out_ready & (state_reg == OUT);

  always_comb begin
    sum_wide = {1'b0, acc_reg} + SW'(pc_reg);
    sum_ovf  = sum_wide[ACC_W];
    sum_sat  = sum_ovf ? '1 : sum_wide[ACC_W-1:0];
  end

  // DRAIN waits for the stage register to empty so the last count is in acc.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (accept && bus.in_last) state_next = DRAIN;
      DRAIN:   if (!pc_valid_reg)         state_next = OUT;
      OUT:     if (bus.out_ready)         state_next = RUN;
      default:                            state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      pc_reg       <= '0;
      pc_valid_reg <= 1'b0;
      pc_last_reg  <= 1'b0;
      acc_reg      <= '0;
      sat_reg      <= 1'b0;
      out_cnt_reg  <= '0;
      out_sat_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_valid_reg <= accept;
      if (accept) begin
        pc_reg      <= pc;
        pc_last_reg <= bus.in_last;
      end
      if (consume) begin
        acc_reg <= '0;
        sat_reg <= 1'b0;
      end else if (pc_valid_reg) begin
        acc_reg <= sum_sat;
        sat_reg <= sat_reg | sum_ovf;
      end
      if (pc_valid_reg && pc_last_reg) begin
        out_cnt_reg <= sum_sat;
        out_sat_reg <= sat_reg | sum_ovf;
      end
    end
  end

  assign bus.in_ready  = (state_reg == RUN);
  assign bus.out_valid = (state_reg == OUT);
  assign bus.out_cnt   = out_cnt_reg;
  assign bus.out_sat   = out_sat_reg;

endmodule

// File: tb/tb_cprs_popcnt_acc.sv
// Bench for cprs_popcnt_acc: three instances (7b/16b, 7b/4b, 8b/16b) share one
// stimulus; a frame-sum model feeds per-instance result queues checked every cycle.
module tb_cprs_popcnt_acc;

`ifdef CPRS_APPROX_EN
  localparam bit APX = 1'b1;
`else
  localparam bit APX = 1'b0;
`endif

  typedef struct {
    longint cnt;
    bit     sat;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  longint sum7 = 0;
  longint sum8 = 0;
  res_t qa[$];
  res_t qb[$];
  res_t qc[$];
  longint cap_a, cap_b, cap_c;
  bit cap_bsat;

  always #5 clk = ~clk;

  cprs_popcnt_acc_if #(.N_IN(7), .ACC_W(16)) ia ();
  cprs_popcnt_acc_if #(.N_IN(7), .ACC_W(4))  ib ();
  cprs_popcnt_acc_if #(.N_IN(8), .ACC_W(16)) ic ();

  assign ia.in_data = in_data[6:0];
  assign ib.in_data = in_data[6:0];
  assign ic.in_data = in_data;
  assign ia.in_valid = in_valid;
  assign ib.in_valid = in_valid;
  assign ic.in_valid = in_valid;
  assign ia.in_last = in_last;
  assign ib.in_last = in_last;
  assign ic.in_last = in_last;
  assign ia.out_ready = out_ready;
  assign ib.out_ready = out_ready;
  assign ic.out_ready = out_ready;

  cprs_popcnt_acc #(.N_IN(7), .ACC_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  cprs_popcnt_acc #(.N_IN(7), .ACC_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ib));
  cprs_popcnt_acc #(.N_IN(8), .ACC_W(16)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  function automatic void chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Count of one beat from the counting rules (exact, or grouped approximation).
  function automatic longint beat_count(input logic [7:0] d, input int n);
    longint r = 0;
    int ng = APX ? n / 4 : 0;
    for (int g = 0; g < ng; g++) begin
      int a = d[4*g], b = d[4*g+1], c = d[4*g+2], e = d[4*g+3];
      r += 2 * ((a & b) | (c & e)) + ((a ^ b) | (c ^ e));
    end
    for (int i = 4 * ng; i < n; i++) r += d[i];
    return r;
  endfunction

  function automatic res_t clamp(input longint s, input int w);
    res_t r;
    longint mx = (longint'(1) << w) - 1;
    r.cnt = (s > mx) ? mx : s;
    r.sat = (s > mx);
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input bit last);
    int k = 0;
    in_data = d;
    in_valid = 1'b1;
    in_last = last;
    while (!ia.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    sum7 += beat_count(d, 7);
    sum8 += beat_count(d, 8);
    if (last) begin
      qa.push_back(clamp(sum7, 16));
      qb.push_back(clamp(sum7, 4));
      qc.push_back(clamp(sum8, 16));
      sum7 = 0;
      sum8 = 0;
    end
  endtask

  task automatic recv();
    int k = 0;
    out_ready = 1'b1;
    while (!ia.out_valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 30) chk("recv_timeout", 0, 1);
    cap_a = longint'(ia.out_cnt);
    cap_b = longint'(ib.out_cnt);
    cap_bsat = ib.out_sat;
    cap_c = longint'(ic.out_cnt);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ia.out_valid) begin
        if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
        else begin
          chk("a_out_cnt", longint'(ia.out_cnt), qa[0].cnt);
          chk("a_out_sat", longint'(ia.out_sat), longint'(qa[0].sat));
          if (ia.out_ready) void'(qa.pop_front());
        end
      end
      if (ib.out_valid) begin
        if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
        else begin
          chk("b_out_cnt", longint'(ib.out_cnt), qb[0].cnt);
          chk("b_out_sat", longint'(ib.out_sat), longint'(qb[0].sat));
          if (ib.out_ready) void'(qb.pop_front());
        end
      end
      if (ic.out_valid) begin
        if (qc.size() == 0) chk("c_unexpected_valid", 1, 0);
        else begin
          chk("c_out_cnt", longint'(ic.out_cnt), qc[0].cnt);
          chk("c_out_sat", longint'(ic.out_sat), longint'(qc[0].sat));
          if (ic.out_ready) void'(qc.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", longint'(ia.in_ready), 1);
    chk("reset_out_valid", longint'(ia.out_valid), 0);
    chk("reset_out_cnt", longint'(ia.out_cnt), 0);
    chk("reset_out_sat", longint'(ia.out_sat), 0);
    $display("reset released");

    // single full beat: latency to out_valid is two edges after acceptance
    send(8'h7F, 1'b1);
    chk("lat_t_in_ready", longint'(ia.in_ready), 0);
    chk("lat_t_out_valid", longint'(ia.out_valid), 0);
    idle(1);
    chk("lat_t1_out_valid", longint'(ia.out_valid), 0);
    idle(1);
    chk("lat_t2_out_valid", longint'(ia.out_valid), 1);
    recv();
    chk("single_7f_cnt", cap_a, APX ? 5 : 7);
    $display("frame 7F: a=%0d", cap_a);

    // four beats with idle gaps
    send(8'h55, 1'b0); idle(2);
    send(8'h00, 1'b0); idle(1);
    send(8'h7F, 1'b0); idle(3);
    send(8'h01, 1'b1);
    recv();
    chk("four_beat_cnt", cap_a, APX ? 9 : 12);
    $display("frame 55,00,7F,01: a=%0d", cap_a);

    // saturation in the 4-bit accumulator
    send(8'h7F, 1'b0);
    send(8'h7F, 1'b0);
    send(8'h7F, 1'b1);
    recv();
    chk("sat_b_cnt", cap_b, 15);
    chk("sat_b_flag", longint'(cap_bsat), APX ? 0 : 1);
    chk("sat_a_cnt", cap_a, APX ? 15 : 21);
    $display("frame 3x7F: a=%0d b=%0d sat=%0d", cap_a, cap_b, cap_bsat);

    // result held while out_ready is low
    send(8'h0F, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", longint'(ia.out_valid), 1);
      chk("hold_in_ready", longint'(ia.in_ready), 0);
      chk("hold_out_cnt", longint'(ia.out_cnt), APX ? 2 : 4);
      idle(1);
    end
    recv();
    chk("return_in_ready", longint'(ia.in_ready), 1);
    send(8'h01, 1'b1);
    recv();
    chk("after_hold_cnt", cap_a, 1);
    $display("frame 0F held, then 01: a=%0d", cap_a);

    // reset mid-frame discards the partial sum
    send(8'h7F, 1'b0);
    send(8'h7F, 1'b0);
    rst = 1'b1;
    sum7 = 0;
    sum8 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", longint'(ia.in_ready), 1);
    chk("midrst_out_valid", longint'(ia.out_valid), 0);
    chk("midrst_out_cnt", longint'(ia.out_cnt), 0);
    chk("midrst_out_sat", longint'(ib.out_sat), 0);
    send(8'h03, 1'b1);
    recv();
    chk("after_rst_cnt", cap_a, 2);
    $display("reset mid-frame, then 03: a=%0d", cap_a);

    // all-zero frame and 8-bit full beat
    send(8'h00, 1'b1);
    recv();
    chk("zero_cnt", cap_a, 0);
    $display("frame 00: a=%0d", cap_a);
    send(8'hFF, 1'b1);
    recv();
    chk("ff8_cnt", cap_c, APX ? 4 : 8);
    $display("frame FF (8b): c=%0d", cap_c);

    idle(4);
    chk("qa_drained", longint'(qa.size()), 0);
    chk("qb_drained", longint'(qb.size()), 0);
    chk("qc_drained", longint'(qc.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
